// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide execute unit: one op at a time, result returned with its tag.
// Latency: multiply and divide special cases 1 cycle; general divide XLEN+1 cycles.
// Backpressure: in_ready only in IDLE without flush; a result is held in DONE until out_ready.
//
// Ports: clk, rstn (async active-low), flush (sync abort), in_valid/in_ready + funct3,
// rs1_data, rs2_data, in_tag (request); out_valid/out_ready + out_data, out_tag (result); busy.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
    logic            neg_res;   // negate the final result (sign already resolved for quo/rem)
    logic            is_rem;

    logic            accept;
    logic            is_div, div_signed, want_rem;
    logic            rs1_neg, rs2_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res, abs1, abs2;
    logic            a_sgn, b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0] mul_res;
    logic [XLEN:0]   shifted, diff;
    logic            borrow;
    logic [XLEN-1:0] step_rem, step_quo, fin_raw, fin_res;

    // Reset gating keeps in_ready low while the unit is held in reset.
    assign in_ready  = rstn && (state == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Request decode (divide fields only meaningful when funct3[2] is set)
    assign is_div     = funct3[2];
    assign div_signed = ~funct3[0];
    assign want_rem   = funct3[1];
    assign rs1_neg    = div_signed & rs1_data[XLEN-1];
    assign rs2_neg    = div_signed & rs2_data[XLEN-1];
    assign div_zero   = (rs2_data == '0);
    assign div_ovf    = div_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    assign special    = div_zero || div_ovf;
    assign special_res = div_zero ? (want_rem ? rs1_data : '1)
                                  : (want_rem ? '0 : rs1_data);
    assign abs1 = rs1_neg ? -rs1_data : rs1_data;
    assign abs2 = rs2_neg ? -rs2_data : rs2_data;

    // Multiply: sign-extend to 2*XLEN so one unsigned multiplier covers all four forms.
    assign a_sgn   = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
    assign b_sgn   = (funct3[1:0] == 2'b01);
    assign mul_a   = {{XLEN{a_sgn & rs1_data[XLEN-1]}}, rs1_data};
    assign mul_b   = {{XLEN{b_sgn & rs2_data[XLEN-1]}}, rs2_data};
    assign prod    = mul_a * mul_b;
    assign mul_res = (funct3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // One restoring step; rem < divisor always, so XLEN+1 bits hold the shifted value.
    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, dvsr_q};
    assign borrow   = diff[XLEN];
    assign step_rem = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign step_quo = {quo_q[XLEN-2:0], ~borrow};
    assign fin_raw  = is_rem ? step_rem : step_quo;
    assign fin_res  = neg_res ? -fin_raw : fin_raw;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (is_div && !special) ? DIV : DONE;
            DIV:  if (cnt == CW'(1)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_res  <= 1'b0;
            is_rem   <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
        end else if (accept) begin
            out_tag <= in_tag;
            if (!is_div) begin
                out_data <= mul_res;
            end else if (special) begin
                out_data <= special_res;
            end else begin
                rem_q   <= '0;
                quo_q   <= abs1;
                dvsr_q  <= abs2;
                cnt     <= CW'(XLEN);
                is_rem  <= want_rem;
                neg_res <= want_rem ? rs1_neg : (rs1_neg ^ rs2_neg);
            end
        end else if (flush) begin
            cnt <= '0;
        end else if (state == DIV) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) out_data <= fin_res;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic        clk, rstn, flush, in_valid, out_ready;
    logic        in_ready, out_valid, busy;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, out_data;
    logic [4:0]  in_tag, out_tag;

    logic        flush64, in_valid64, out_ready64, in_ready64, out_valid64, busy64;
    logic [2:0]  funct3_64;
    logic [63:0] rs1_64, rs2_64, out_data64;
    logic [4:0]  in_tag64, out_tag64;

    int vectors = 0;
    int errors  = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .busy(busy)
    );

    muldiv_unit #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
        .funct3(funct3_64), .rs1_data(rs1_64), .rs2_data(rs2_64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64), .out_tag(out_tag64),
        .busy(busy64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic on the RISC-V M semantics.
    function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y, p;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (!f[2]) begin
            x = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
            y = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
            p = x * y;
            return (f == 3'b000) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
            return f[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2] || b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        funct3 = f; rs1_data = a; rs2_data = b; in_tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, holds for 'hold' cycles, then takes the result.
    task automatic collect(input int max, input int hold, output logic [31:0] d, output logic [4:0] t,
                           output int lat, output bit busy_ok, output bit stable);
        lat = 1; busy_ok = 1'b1; stable = 1'b1;
        while (out_valid !== 1'b1 && lat <= max) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        d = out_data; t = out_tag;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== d || out_tag !== t || in_ready !== 1'b0) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if ({out_valid, busy, in_ready, out_data, out_tag} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: v=%b busy=%b rdy=%b data=%h tag=%h, required all 0",
                     out_valid, busy, in_ready, out_data, out_tag);
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1/0", in_ready, busy);
        end
    endtask

    task automatic run_directed(input string name, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] d; logic [4:0] t; int lat; bit bok, st;
        logic [4:0] tag;
        tag = 5'($urandom);
        issue(f, a, b, tag);
        collect(40, 0, d, t, lat, bok, st);
        vectors++;
        if (d !== exp || t !== tag || lat != exp_lat || !bok) begin
            errors++;
            $display("FAIL %s: data=%h tag=%0d lat=%0d busy_ok=%0d, required data=%h tag=%0d lat=%0d busy_ok=1",
                     name, d, t, lat, bok, exp, tag, exp_lat);
        end
    endtask

    task automatic test_mul;
        logic [31:0] d; logic [4:0] t; int lat; bit bok, st;
        issue(3'b000, 32'd7, -32'sd3, 5'd5);
        collect(40, 0, d, t, lat, bok, st);
        vectors++;
        if (d !== 32'hFFFF_FFEB || t !== 5'd5 || lat != 1) begin
            errors++;
            $display("FAIL mul_7x-3: data=%h tag=%0d lat=%0d, required FFFFFFEB 5 1", d, t, lat);
        end
        run_directed("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        run_directed("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_directed("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    endtask

    task automatic test_div;
        run_directed("div_-7_2", 3'b100, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33);
        run_directed("rem_-7_2", 3'b110, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33);
        run_directed("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_directed("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    endtask

    task automatic test_special;
        run_directed("div_by_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_directed("remu_by_0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
        run_directed("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_directed("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    endtask

    task automatic test_backpressure;
        logic [31:0] a, b, exp;
        int bad;
        a = $urandom; b = $urandom; exp = ref32(3'b011, a, b);
        issue(3'b011, a, b, 5'd19);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== exp || out_tag !== 5'd19 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles (data=%h), required 0 (data=%h)", bad, out_data, exp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush;
        int seen;
        logic [31:0] exp;
        issue(3'b101, 32'd1000, 32'd7, 5'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%b out_valid=%b, required 0/0", busy, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_result: out_valid seen %0d cycles, required 0", seen);
        end
        // Flush in DONE with out_ready high discards the result; data holds.
        exp = ref32(3'b000, 32'd9, 32'd11);
        issue(3'b000, 32'd9, 32'd11, 5'd8);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== exp || out_tag !== 5'd8) begin
            errors++;
            $display("FAIL flush_done: v=%b busy=%b data=%h tag=%0d, required 0 0 %h 8",
                     out_valid, busy, out_data, out_tag, exp);
        end
    endtask

    task automatic test_async_reset;
        issue(3'b100, 32'd12345, 32'd17, 5'd21);
        repeat (5) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        vectors++;
        if ({out_valid, busy, in_ready, out_data, out_tag} !== 40'd0) begin
            errors++;
            $display("FAIL async_reset: v=%b busy=%b rdy=%b data=%h tag=%h, required all 0",
                     out_valid, busy, in_ready, out_data, out_tag);
        end
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        run_directed("mul_after_reset", 3'b000, 32'd3, 32'd4, 32'd12, 1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [2:0] f; logic [31:0] a, b, d, exp; logic [4:0] tag, t;
        int lat, hold; bit bok, st;
        for (int n = 0; n < 150; n++) begin
            f = 3'($urandom); a = pick_operand(); b = pick_operand(); tag = 5'($urandom);
            hold = $urandom_range(0, 3);
            exp = ref32(f, a, b);
            vectors++;
            if (in_ready !== ~busy) begin
                errors++;
                $display("FAIL rand_complement: in_ready=%b busy=%b", in_ready, busy);
            end
            issue(f, a, b, tag);
            collect(40, hold, d, t, lat, bok, st);
            vectors++;
            if (d !== exp || t !== tag || lat != ref_lat(f, a, b) || !st) begin
                errors++;
                $display("FAIL rand f=%b a=%h b=%h: data=%h tag=%0d lat=%0d stable=%0d, required %h %0d %0d 1",
                         f, a, b, d, t, lat, st, exp, tag, ref_lat(f, a, b));
            end
        end
    endtask

    task automatic run64(input string name, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        funct3_64 = f; rs1_64 = a; rs2_64 = b; in_tag64 = 5'd11; in_valid64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        lat = 1;
        while (out_valid64 !== 1'b1 && lat <= 80) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (out_data64 !== exp || lat != exp_lat || out_tag64 !== 5'd11) begin
            errors++;
            $display("FAIL %s: data=%h lat=%0d tag=%0d, required %h %0d 11", name, out_data64, lat, out_tag64, exp, exp_lat);
        end
        out_ready64 = 1'b1;
        @(posedge clk); #1;
        out_ready64 = 1'b0;
    endtask

    task automatic test_xlen64;
        run64("divu64", 3'b101, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 65);
        run64("mulhu64", 3'b011, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 1);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        funct3 = '0; rs1_data = '0; rs2_data = '0; in_tag = '0;
        flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b0;
        funct3_64 = '0; rs1_64 = '0; rs2_64 = '0; in_tag64 = '0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        test_xlen64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
